// File: rtl/spart_rx_deser_if.sv
// Bus-side signal bundle of the SPART receive deserializer.
// SPART_RX_FRAME_CHECK_EN adds the framing_err signal.
interface spart_rx_deser_if;
  logic       rxd;
  logic [15:0] divisor_buffer;
  logic       rda_clr;
  logic [9:0] rx_shift_reg;
  logic       rda;
  logic       rx_busy;
`ifdef SPART_RX_FRAME_CHECK_EN
  logic       framing_err;

  modport master (
    output rxd, divisor_buffer, rda_clr,
    input  rx_shift_reg, rda, rx_busy, framing_err
  );
  modport slave (
    input  rxd, divisor_buffer, rda_clr,
    output rx_shift_reg, rda, rx_busy, framing_err
  );
`else
  modport master (
    output rxd, divisor_buffer, rda_clr,
    input  rx_shift_reg, rda, rx_busy
  );
  modport slave (
    input  rxd, divisor_buffer, rda_clr,
    output rx_shift_reg, rda, rx_busy
  );
`endif
endinterface

// File: rtl/spart_rx_deser.sv
// SPART receive deserializer: 16x-oversampled 8N1 frame assembly with data-available flag.
// Optional SPART_RX_FRAME_CHECK_EN: stop bit 0 raises framing_err instead of rda.
module spart_rx_deser #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  spart_rx_deser_if.slave rx_if
);

  localparam int unsigned OsW = $clog2(OVERSAMPLE);
  localparam logic [OsW-1:0] OsHalf = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxd_s;
  logic [15:0]            r_tick_cnt;
  logic                   w_tick;
  state_e                 r_state, w_state_d;
  logic [OsW-1:0]         r_os_cnt, w_os_d;
  logic [2:0]             r_bit_cnt, w_bit_d;
  logic [7:0]             r_data, w_data_d;
  logic [9:0]             r_frame, w_frame_d;
  logic                   r_rda, w_rda_d;
  logic                   w_done;
`ifdef SPART_RX_FRAME_CHECK_EN
  logic                   r_ferr, w_ferr_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_if.rxd};
    end
  end
  assign w_rxd_s = r_sync[SYNC_STAGES-1];

  // Reset count of 0 fires one tick straight away; the divisor governs phase from the reload on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= rx_if.divisor_buffer;
    end else begin
      r_tick_cnt <= r_tick_cnt - 16'd1;
    end
  end
  assign w_tick = (r_tick_cnt == 16'd0);

  always_comb begin
    w_state_d = r_state;
    w_os_d    = r_os_cnt;
    w_bit_d   = r_bit_cnt;
    w_data_d  = r_data;
    w_frame_d = r_frame;
    w_done    = 1'b0;
    if (w_tick) begin
      w_os_d = r_os_cnt + 1'b1;
      unique case (r_state)
        StIdle: begin
          if (!w_rxd_s) begin
            w_state_d = StStart;
            w_os_d    = '0;
          end
        end
        StStart: begin
          if (r_os_cnt == OsHalf) begin
            w_os_d = '0;
            if (w_rxd_s) begin
              w_state_d = StIdle;
            end else begin
              w_state_d = StData;
              w_bit_d   = 3'd0;
            end
          end
        end
        StData: begin
          if (r_os_cnt == OsLast) begin
            w_data_d = {w_rxd_s, r_data[7:1]};
            w_bit_d  = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_d = StStop;
              w_os_d    = '0;
            end
          end
        end
        StStop: begin
          if (r_os_cnt == OsLast) begin
            w_frame_d = {w_rxd_s, r_data, 1'b0};
            w_done    = 1'b1;
            w_state_d = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // A completing frame outranks a same-cycle read clear so it is never lost.
  always_comb begin
    w_rda_d = r_rda;
    if (rx_if.rda_clr) w_rda_d = 1'b0;
`ifdef SPART_RX_FRAME_CHECK_EN
    w_ferr_d = r_ferr;
    if (rx_if.rda_clr) w_ferr_d = 1'b0;
    if (w_done) begin
      if (w_rxd_s) begin
        w_rda_d  = 1'b1;
        w_ferr_d = 1'b0;
      end else begin
        w_ferr_d = 1'b1;
      end
    end
`else
    if (w_done) w_rda_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_data    <= '0;
      r_frame   <= 10'h3FF;
      r_rda     <= 1'b0;
`ifdef SPART_RX_FRAME_CHECK_EN
      r_ferr    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_os_cnt  <= w_os_d;
      r_bit_cnt <= w_bit_d;
      r_data    <= w_data_d;
      r_frame   <= w_frame_d;
      r_rda     <= w_rda_d;
`ifdef SPART_RX_FRAME_CHECK_EN
      r_ferr    <= w_ferr_d;
`endif
    end
  end

  assign rx_if.rx_shift_reg = r_frame;
  assign rx_if.rda          = r_rda;
  assign rx_if.rx_busy      = (r_state != StIdle);
`ifdef SPART_RX_FRAME_CHECK_EN
  assign rx_if.framing_err  = r_ferr;
`endif

endmodule

// File: tb/tb_spart_rx_deser.sv
// Scoreboard bench for spart_rx_deser: frames are queued when driven, checked on completion.
module tb_spart_rx_deser;

  logic clk = 1'b0;
  logic rst = 1'b0;
  spart_rx_deser_if bus ();

  spart_rx_deser #(
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rx_if(bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          bit_clks = 16;
  logic [9:0]  sb[$];
  logic [9:0]  mon_exp;
  logic        busy_prev = 1'b0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Frame completion: rx_busy falls while a frame is outstanding.
  always @(negedge clk) begin
    if (busy_prev && !bus.rx_busy && sb.size() > 0) begin
      mon_exp = sb.pop_front();
      check_val("sb_frame", 16'(bus.rx_shift_reg), 16'(mon_exp));
`ifdef SPART_RX_FRAME_CHECK_EN
      check_val("sb_rda", 16'(bus.rda), 16'(mon_exp[9]));
      check_val("sb_ferr", 16'(bus.framing_err), 16'(!mon_exp[9]));
`else
      check_val("sb_rda", 16'(bus.rda), 16'd1);
`endif
    end
    busy_prev = bus.rx_busy;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit clr_at_stop);
    logic [9:0] f;
    int len;
    f = {stop, d, 1'b0};
    sb.push_back(f);
    for (int k = 0; k < 10; k++) begin
      len = bit_clks;
      bus.rxd = f[k];
      if (k == 9) begin
        if (clr_at_stop) bus.rda_clr = 1'b1;
        // Short low stop bit so the idle re-detect sees a false start, not a new frame.
        if (!stop) len = bit_clks * 3 / 4;
      end
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (k == 9 && clr_at_stop && bus.rda_clr && !bus.rx_busy) bus.rda_clr = 1'b0;
      end
    end
    bus.rda_clr = 1'b0;
    bus.rxd = 1'b1;
    if (!stop) repeat (bit_clks / 4) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && sb.size() > 0; i++) @(negedge clk);
    check_val("drain", 16'(sb.size()), 16'd0);
    sb.delete();
  endtask

  task automatic pulse_clr(input string tag);
    bus.rda_clr = 1'b1;
    @(negedge clk);
    bus.rda_clr = 1'b0;
    check_val(tag, 16'(bus.rda), 16'd0);
  endtask

  initial begin
    bus.rxd            = 1'b1;
    bus.divisor_buffer = 16'h0000;
    bus.rda_clr        = 1'b0;
    rst                = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_frame", 16'(bus.rx_shift_reg), 16'h03FF);
    check_val("rst_rda", 16'(bus.rda), 16'd0);
    check_val("rst_busy", 16'(bus.rx_busy), 16'd0);
`ifdef SPART_RX_FRAME_CHECK_EN
    check_val("rst_ferr", 16'(bus.framing_err), 16'd0);
`endif
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Short glitch: false start, nothing reported
    bus.rxd = 1'b0;
    repeat (4) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_val("glitch_rda", 16'(bus.rda), 16'd0);
    check_val("glitch_frame", 16'(bus.rx_shift_reg), 16'h03FF);
    check_val("glitch_busy", 16'(bus.rx_busy), 16'd0);

    send_frame(8'hA5, 1'b1, 1'b0);
    wait_drain();
    check_val("a5_frame", 16'(bus.rx_shift_reg), 16'h034A);
    check_val("a5_busy", 16'(bus.rx_busy), 16'd0);
    pulse_clr("a5_clr");

    // Slower baud: 64 clks per bit
    bus.divisor_buffer = 16'h0003;
    bit_clks = 64;
    repeat (10) @(negedge clk);
    send_frame(8'h00, 1'b1, 1'b0);
    check_val("x00_frame", 16'(bus.rx_shift_reg), 16'h0200);
    pulse_clr("x00_clr");
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_drain();
    check_val("xff_frame", 16'(bus.rx_shift_reg), 16'h03FE);
    check_val("xff_rda", 16'(bus.rda), 16'd1);
    pulse_clr("xff_clr");

    // Overrun, then read clear coinciding with completion
    bus.divisor_buffer = 16'h0000;
    bit_clks = 16;
    repeat (80) @(negedge clk);
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    wait_drain();
    check_val("ovr_frame", 16'(bus.rx_shift_reg), 16'h0268);
    check_val("ovr_rda", 16'(bus.rda), 16'd1);
    send_frame(8'h81, 1'b1, 1'b1);
    wait_drain();
    check_val("setwin_rda", 16'(bus.rda), 16'd1);
    pulse_clr("setwin_clr");

    // Stop bit forced low
    send_frame(8'h5A, 1'b0, 1'b0);
    wait_drain();
    repeat (30) @(negedge clk);
    check_val("brk_frame", 16'(bus.rx_shift_reg), 16'h00B4);
    check_val("brk_busy", 16'(bus.rx_busy), 16'd0);
`ifdef SPART_RX_FRAME_CHECK_EN
    check_val("brk_rda", 16'(bus.rda), 16'd0);
    check_val("brk_ferr", 16'(bus.framing_err), 16'd1);
`else
    check_val("brk_rda", 16'(bus.rda), 16'd1);
`endif
    pulse_clr("brk_clr");

    // Reset in the middle of data bit 4
    send_frame(8'h66, 1'b1, 1'b0);
    wait_drain();
    bus.rxd = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      bus.rxd = k[0] ? 1'b1 : 1'b1;
      repeat (bit_clks) @(negedge clk);
    end
    bus.rxd = 1'b0;
    repeat (bit_clks / 2) @(negedge clk);
    check_val("mid_busy", 16'(bus.rx_busy), 16'd1);
    rst = 1'b0;
    #1;
    check_val("mid_rst_frame", 16'(bus.rx_shift_reg), 16'h03FF);
    check_val("mid_rst_rda", 16'(bus.rda), 16'd0);
    check_val("mid_rst_busy", 16'(bus.rx_busy), 16'd0);
    @(negedge clk);
    bus.rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_drain();
    check_val("x3c_frame", 16'(bus.rx_shift_reg), 16'h0278);
    check_val("x3c_rda", 16'(bus.rda), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
